ml_input_deserializer: RTL and testbench

Input-side counterpart of the ML detector's output serializer. It accepts a 1-bit serial stream under a valid/ready handshake and packs the bits LSB-first into DATA_WIDTH-bit words. Completed words are buffered in an internal first-word-fall-through FIFO, tagged with an end-of-frame flag, and presented to the detector core under a second valid/ready handshake. It sits between the testbench/pad-side bit stream and the detector's word-wide input port.

---
 rtl/ml_input_deserializer_if.sv | 37 +++
 rtl/ml_input_deserializer.sv | 95 +++++++++
 tb/tb_ml_input_deserializer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ml_input_deserializer_if.sv
// Handshake bundle between the serial bit source, the deserializer and the detector core.
// The slave modport is the deserializer side; the master modport is the stream source and word sink.
interface ml_input_deserializer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    logic                    i_rx_vld;
    logic                    i_rx_bit;
    logic                    o_rx_rdy;
    logic                    o_word_vld;
    logic [DATA_WIDTH-1:0]   o_word_data;
    logic                    o_word_last;
    logic                    i_word_rdy;
    logic [$clog2(DEPTH):0]  o_fifo_cnt;

    modport slave (
        input  i_rx_vld,
        input  i_rx_bit,
        output o_rx_rdy,
        output o_word_vld,
        output o_word_data,
        output o_word_last,
        input  i_word_rdy,
        output o_fifo_cnt
    );

    modport master (
        output i_rx_vld,
        output i_rx_bit,
        input  o_rx_rdy,
        input  o_word_vld,
        input  o_word_data,
        input  o_word_last,
        output i_word_rdy,
        input  o_fifo_cnt
    );
endinterface

// File: rtl/ml_input_deserializer.sv
// Packs an LSB-first serial bit stream into words, tags frame ends and buffers them
// in a first-word-fall-through FIFO toward the detector core. DATA_WIDTH must be at least 2.
module ml_input_deserializer #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int FRAME_WORDS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    ml_input_deserializer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int FW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_WIDTH - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_WORDS - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [BW-1:0]         bit_cnt;
    logic [FW-1:0]         fw_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    logic                  last_bit;
    logic                  rx_rdy;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] word_in;

    // Only the word-completing bit is ever held back, and only by registered fullness.
    always_comb begin
        last_bit = (bit_cnt == BIT_LAST);
        rx_rdy   = ~(last_bit & (count == COUNT_FULL));
        accept   = bus.i_rx_vld & rx_rdy;
        push     = accept & last_bit;
        pop      = (count != '0) & bus.i_word_rdy;
        word_in  = {bus.i_rx_bit, shift_reg[DATA_WIDTH-1:1]};
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            bit_cnt   <= '0;
            fw_cnt    <= '0;
            shift_reg <= '0;
        end else if (accept) begin
            shift_reg <= {bus.i_rx_bit, shift_reg[DATA_WIDTH-1:1]};
            bit_cnt   <= last_bit ? '0 : bit_cnt + BW'(1);
            if (push) begin
                fw_cnt <= (fw_cnt == FRAME_LAST) ? '0 : fw_cnt + FW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= {(fw_cnt == FRAME_LAST), word_in};
        end
    end

    // Simultaneous push and pop leave the occupancy unchanged.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push & ~pop) begin
                count <= count + CW'(1);
            end else if (pop & ~push) begin
                count <= count - CW'(1);
            end
        end
    end

    assign bus.o_rx_rdy    = rx_rdy;
    assign bus.o_word_vld  = (count != '0);
    assign bus.o_word_data = mem[rd_ptr][DATA_WIDTH-1:0];
    assign bus.o_word_last = mem[rd_ptr][DATA_WIDTH];
    assign bus.o_fifo_cnt  = count;
endmodule

// File: tb/tb_ml_input_deserializer.sv
// Directed self-checking bench for ml_input_deserializer (DATA_WIDTH=8, DEPTH=16, FRAME_WORDS=4).
module tb_ml_input_deserializer;
    logic i_clk;
    logic i_reset;
    int   total;
    int   bad;
    logic [7:0] got_data[$];
    logic       got_last[$];
    logic       check_stall;
    logic       stall_prev;
    logic [7:0] prev_data;

    ml_input_deserializer_if #(.DATA_WIDTH(8), .DEPTH(16)) bus ();

    ml_input_deserializer #(
        .DATA_WIDTH (8),
        .DEPTH      (16),
        .FRAME_WORDS(4)
    ) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .bus    (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic apply_stimulus(input logic b);
        int guard;
        guard = 0;
        bus.i_rx_vld = 1'b1;
        bus.i_rx_bit = b;
        while (bus.o_rx_rdy !== 1'b1 && guard < 200) begin
            tick(1);
            guard++;
        end
        if (guard >= 200) begin
            total++;
            bad++;
            $error("[TB] FAIL rx_rdy_timeout: observed=0 expected=1");
        end
        tick(1);
        bus.i_rx_vld = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(w[i]);
        end
    endtask

    task automatic pulse_reset();
        bus.i_rx_vld   = 1'b0;
        bus.i_word_rdy = 1'b0;
        i_reset = 1'b1;
        tick(1);
        i_reset = 1'b0;
        got_data.delete();
        got_last.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_rx_rdy"}, 32'(bus.o_rx_rdy), 32'd1);
        check_output({tag, "_word_vld"}, 32'(bus.o_word_vld), 32'd0);
        check_output({tag, "_word_data"}, 32'(bus.o_word_data), 32'h0);
        check_output({tag, "_word_last"}, 32'(bus.o_word_last), 32'd0);
        check_output({tag, "_fifo_cnt"}, 32'(bus.o_fifo_cnt), 32'd0);
    endtask

    task automatic check_popped(input string tag, input int idx, input logic [7:0] d, input logic l);
        check_output({tag, "_data"}, (idx < got_data.size()) ? 32'(got_data[idx]) : 32'hxxxxxxxx, 32'(d));
        check_output({tag, "_last"}, (idx < got_last.size()) ? 32'(got_last[idx]) : 32'hxxxxxxxx, 32'(l));
    endtask

    // Pops are decided by values that are stable at the falling edge before the popping edge.
    always @(negedge i_clk) begin
        if (i_reset) begin
            stall_prev = 1'b0;
        end else begin
            if (check_stall && stall_prev) begin
                check_output("stall_vld", 32'(bus.o_word_vld), 32'd1);
                check_output("stall_data", 32'(bus.o_word_data), 32'(prev_data));
            end
            if (bus.o_word_vld === 1'b1 && bus.i_word_rdy === 1'b1) begin
                got_data.push_back(bus.o_word_data);
                got_last.push_back(bus.o_word_last);
            end
            stall_prev = (bus.o_word_vld === 1'b1) && (bus.i_word_rdy === 1'b0);
            prev_data  = bus.o_word_data;
        end
    end

    initial begin
        logic [7:0] single_bits;
        total          = 0;
        bad            = 0;
        check_stall    = 1'b0;
        stall_prev     = 1'b0;
        prev_data      = '0;
        i_reset        = 1'b0;
        bus.i_rx_vld   = 1'b0;
        bus.i_rx_bit   = 1'b0;
        bus.i_word_rdy = 1'b0;

        // Asynchronous reset asserted mid-cycle
        @(posedge i_clk);
        #3;
        i_reset = 1'b1;
        #1;
        check_reset_outputs("reset");
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;

        $display("[TB] single word 0x4D");
        bus.i_word_rdy = 1'b1;
        single_bits = 8'b0100_1101;
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(single_bits[i]);
        end
        check_output("single_pre_vld", 32'(bus.o_word_vld), 32'd0);
        check_output("single_pre_cnt", 32'(bus.o_fifo_cnt), 32'd0);
        apply_stimulus(single_bits[7]);
        check_output("single_vld", 32'(bus.o_word_vld), 32'd1);
        check_output("single_data", 32'(bus.o_word_data), 32'h4D);
        check_output("single_cnt", 32'(bus.o_fifo_cnt), 32'd1);
        tick(1);
        check_output("single_post_vld", 32'(bus.o_word_vld), 32'd0);
        check_output("single_post_cnt", 32'(bus.o_fifo_cnt), 32'd0);
        check_output("single_npop", got_data.size(), 32'd1);
        check_popped("single", 0, 8'h4D, 1'b0);

        $display("[TB] frame tagging");
        pulse_reset();
        bus.i_word_rdy = 1'b1;
        for (int w = 0; w < 8; w++) begin
            send_word(8'(w));
        end
        tick(3);
        check_output("frame_npop", got_data.size(), 32'd8);
        for (int w = 0; w < 8; w++) begin
            check_popped("frame", w, 8'(w), (w == 3 || w == 7));
        end

        $display("[TB] backpressure and wrap");
        pulse_reset();
        for (int w = 0; w < 16; w++) begin
            send_word(8'(8'h10 + w));
        end
        check_output("bp_full_cnt", 32'(bus.o_fifo_cnt), 32'd16);
        check_output("bp_head_data", 32'(bus.o_word_data), 32'h10);
        check_output("bp_head_vld", 32'(bus.o_word_vld), 32'd1);
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(1'b0 ^ (i == 5));
        end
        bus.i_rx_vld = 1'b1;
        bus.i_rx_bit = 1'b0;
        check_output("bp_rdy_low", 32'(bus.o_rx_rdy), 32'd0);
        tick(1);
        check_output("bp_rdy_held", 32'(bus.o_rx_rdy), 32'd0);
        check_output("bp_cnt_held", 32'(bus.o_fifo_cnt), 32'd16);
        bus.i_word_rdy = 1'b1;
        tick(1);
        check_output("bp_rdy_after_pop", 32'(bus.o_rx_rdy), 32'd1);
        check_output("bp_cnt_after_pop", 32'(bus.o_fifo_cnt), 32'd15);
        tick(1);
        bus.i_rx_vld = 1'b0;
        check_output("bp_cnt_push_pop", 32'(bus.o_fifo_cnt), 32'd15);
        tick(20);
        check_output("bp_drained_cnt", 32'(bus.o_fifo_cnt), 32'd0);
        check_output("bp_npop", got_data.size(), 32'd17);
        for (int w = 0; w < 17; w++) begin
            check_popped("bp", w, 8'(8'h10 + w), ((w % 4) == 3));
        end

        $display("[TB] gaps and stalls");
        got_data.delete();
        got_last.delete();
        check_stall = 1'b1;
        single_bits = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                bus.i_word_rdy = 1'($urandom_range(0, 1));
                tick(1);
            end
            if (i == 7) begin
                bus.i_word_rdy = 1'b0;
            end
            apply_stimulus(single_bits[i]);
        end
        tick(2);
        for (int c = 0; c < 6; c++) begin
            bus.i_word_rdy = 1'($urandom_range(0, 1));
            tick(1);
        end
        bus.i_word_rdy = 1'b1;
        tick(4);
        check_stall = 1'b0;
        check_output("gap_npop", got_data.size(), 32'd1);
        check_output("gap_data", (got_data.size() > 0) ? 32'(got_data[0]) : 32'hxxxxxxxx, 32'hC3);
        check_output("gap_cnt", 32'(bus.o_fifo_cnt), 32'd0);

        $display("[TB] reset mid-operation");
        pulse_reset();
        send_word(8'hEE);
        send_word(8'h77);
        apply_stimulus(1'b1);
        apply_stimulus(1'b0);
        apply_stimulus(1'b1);
        check_output("mid_cnt_before", 32'(bus.o_fifo_cnt), 32'd2);
        #2;
        i_reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        got_data.delete();
        got_last.delete();
        bus.i_word_rdy = 1'b1;
        send_word(8'hA5);
        send_word(8'h5A);
        send_word(8'h11);
        send_word(8'h22);
        tick(3);
        check_output("mid_npop", got_data.size(), 32'd4);
        check_popped("mid0", 0, 8'hA5, 1'b0);
        check_popped("mid1", 1, 8'h5A, 1'b0);
        check_popped("mid2", 2, 8'h11, 1'b0);
        check_popped("mid3", 3, 8'h22, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
